// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters with registered, zero-skew sync/blank/frame outputs
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] H_S0   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_S1   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_S0   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_S1   = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] r_hc, r_vc, w_hc_n, w_vc_n;
  logic       r_hs, r_vs, r_blank, r_fs;
  logic [7:0] r_fc;
  logic       w_h_end, w_frame;
  // next-state counters; outputs are decoded from these so they line up with DrawX/DrawY
  always_comb begin
    w_h_end = r_hc == H_LAST;
    w_frame = w_h_end && r_vc == V_LAST;
    w_hc_n  = w_h_end ? '0 : r_hc + 10'd1;
    w_vc_n  = w_frame ? '0 : (w_h_end ? r_vc + 10'd1 : r_vc);
  end
  // counters and registered decode; pixel (0,0) after reset is reported blanked
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc    <= '0;
      r_vc    <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_fs    <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_hc    <= w_hc_n;
      r_vc    <= w_vc_n;
      r_hs    <= !(w_hc_n >= H_S0 && w_hc_n < H_S1);
      r_vs    <= !(w_vc_n >= V_S0 && w_vc_n < V_S1);
      r_blank <= w_hc_n < H_VIS && w_vc_n < V_VIS;
      r_fs    <= w_frame;
      r_fc    <= r_fc + {7'd0, w_frame};
    end
  end
  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_fs;
  assign frame_count = r_fc;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: model-checked bench for a shrunk-timing and a full-timing vga_sync_gen
module tb_vga_sync_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  out_t s, d;
  int total = 0;
  int bad   = 0;

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
    .vga_clk(vga_clk), .reset(reset), .hs(s.hs), .vs(s.vs), .blank(s.blank),
    .DrawX(s.x), .DrawY(s.y), .frame_start(s.fs), .frame_count(s.fc));

  vga_sync_gen dut_d (
    .vga_clk(vga_clk), .reset(reset), .hs(d.hs), .vs(d.vs), .blank(d.blank),
    .DrawX(d.x), .DrawY(d.y), .frame_start(d.fs), .frame_count(d.fc));

  // Raster position follows from the number of clocks since reset released:
  // linear pixel index = k mod frame size, frames completed = k / frame size.
  function automatic out_t model(longint k, bit rst, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    out_t o;
    int ht, x, y;
    longint fr, p;
    ht = ha + hf + hsw + hb;
    fr = longint'(ht) * (va + vf + vsw + vb);
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (rst) return o;
    p = k % fr;
    x = int'(p % ht);
    y = int'(p / ht);
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !(x >= ha + hf && x < ha + hf + hsw);
    o.vs    = !(y >= va + vf && y < va + vf + vsw);
    o.blank = x < ha && y < va;
    o.fs    = p == 0;
    o.fc    = 8'((k / fr) % 256);
    return o;
  endfunction

  longint m_k = 0;
  bit m_rst = 1'b0;
  bit m_v   = 1'b0;
  always @(posedge vga_clk) begin
    if (reset) begin
      m_k   <= 0;
      m_rst <= 1'b1;
      m_v   <= 1'b1;
    end else begin
      m_k   <= m_k + 1;
      m_rst <= 1'b0;
    end
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge vga_clk) begin
    out_t es, ed;
    if (m_v) begin
      es = model(m_k, m_rst, 8, 2, 3, 2, 6, 1, 2, 1);
      ed = model(m_k, m_rst, 640, 16, 96, 48, 480, 10, 2, 33);
      total += 2;
      if (s !== es) begin
        bad++;
        $display("FAIL small_model: got x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d",
                 s.x, s.y, s.hs, s.vs, s.blank, s.fs, s.fc, es.x, es.y, es.hs, es.vs, es.blank, es.fs, es.fc);
      end
      if (d !== ed) begin
        bad++;
        $display("FAIL full_model: got x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d",
                 d.x, d.y, d.hs, d.vs, d.blank, d.fs, d.fc, ed.x, ed.y, ed.hs, ed.vs, ed.blank, ed.fs, ed.fc);
      end
    end
  end

  initial begin
    int hs_cnt_d, hs_first_d, bl_fall_d, wrap_ok_d, vs_cnt_s, vis_bad_s, fs_prev, fs_ivl;
    int prev_xd, prev_fc, wrapped, found;
    hs_cnt_d = 0; hs_first_d = -1; bl_fall_d = -1; wrap_ok_d = 0;
    vs_cnt_s = 0; vis_bad_s = 0; fs_prev = -1; fs_ivl = -1;
    prev_xd = -1; prev_fc = 0; wrapped = 0; found = 0;
    repeat (3) @(negedge vga_clk);
    chk("rst_x", int'(s.x), 0);
    chk("rst_blank", int'(s.blank), 0);
    chk("rst_fc", int'(s.fc), 0);
    chk("rst_hs_vs", int'({s.hs, s.vs}), 3);
    reset = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge vga_clk);
      if (i <= 3) begin
        chk("rel_x", int'(s.x), i);
        chk("rel_blank", int'(s.blank), 1);
      end
      if (d.y == 0) begin
        if (!d.hs) begin
          hs_cnt_d++;
          if (hs_first_d < 0) hs_first_d = int'(d.x);
        end
        if (!d.blank && bl_fall_d < 0) bl_fall_d = int'(d.x);
      end
      if (prev_xd == 799 && d.x == 0 && d.y == 1) wrap_ok_d = 1;
      prev_xd = int'(d.x);
      if (s.fc == 0 && !s.vs) vs_cnt_s++;
      if (s.y >= 6 && s.blank) vis_bad_s++;
      if (s.fs) begin
        if (fs_prev >= 0 && fs_ivl < 0) fs_ivl = i - fs_prev;
        fs_prev = i;
      end
    end
    chk("full_hs_low_cycles", hs_cnt_d, 96);
    chk("full_hs_first_x", hs_first_d, 656);
    chk("full_blank_fall_x", bl_fall_d, 640);
    chk("full_line_wrap", wrap_ok_d, 1);
    chk("small_vs_low_cycles", vs_cnt_s, 30);
    chk("small_blank_below_active", vis_bad_s, 0);
    chk("small_fs_interval", fs_ivl, 150);
    prev_fc = int'(s.fc);
    for (int i = 0; i < 40000 && !wrapped; i++) begin
      @(negedge vga_clk);
      if (prev_fc == 255 && s.fc == 0) wrapped = 1;
      prev_fc = int'(s.fc);
    end
    chk("fc_wrap_255_0", wrapped, 1);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge vga_clk);
      if (s.x == 5 && s.y == 4) found = 1;
    end
    chk("mid_frame_pos_found", found, 1);
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
    chk("mid_rst_xy", int'({s.x, s.y}), 0);
    chk("mid_rst_blank", int'(s.blank), 0);
    chk("mid_rst_hs_vs", int'({s.hs, s.vs}), 3);
    chk("mid_rst_fc", int'(s.fc), 0);
    chk("mid_rst_full_xy", int'({d.x, d.y}), 0);
    @(negedge vga_clk);
    chk("post_rst_x", int'(s.x), 1);
    chk("post_rst_blank", int'(s.blank), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BP, 33, vertical back porch (lines).
REQ-009 vga_clk  in  1  pixel clock (25 MHz); sole clock, all state on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 hs  out  1  horizontal sync, active low.
REQ-012 vs  out  1  vertical sync, active low.
REQ-013 blank  out  1  1 = current pixel is in the visible region (downstream renderers drive colour only when 1), 0 = blanking.
REQ-014 DrawX  out  10  current pixel column, equal to the horizontal counter.
REQ-015 DrawY  out  10  current pixel line, equal to the vertical counter.
REQ-016 frame_start  out  1  one-cycle pulse when DrawX=0 and DrawY=0.
REQ-017 frame_count  out  8  completed-frame counter, wraps 255->0.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-019 Horizontal counter hc increments by 1 every vga_clk cycle; at H_TOTAL-1 it wraps to 0.
REQ-020 Vertical counter vc increments by 1 only in the cycle hc wraps; at V_TOTAL-1 (with hc wrap) it wraps to 0.
REQ-021 DrawX = hc and DrawY = vc, both registered, no other pipeline delay.
REQ-022 hs, vs, blank, frame_start are registered and decoded from the next-state counter values, so all outputs describe the same pixel (DrawX, DrawY) in the same cycle; zero relative skew.
REQ-023 hs = 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751); else 1.
REQ-024 vs = 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line including horizontal blanking; else 1.
REQ-025 blank = 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE; else 0.
REQ-026 frame_start = 1 exactly for the cycle where DrawX=0, DrawY=0; one pulse per frame.
REQ-027 frame_count increments by 1 (mod 256) in the same cycle frame_start rises, i.e. on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition.
REQ-028 Counter widths: hc, vc 10 bits; no value >= H_TOTAL / V_TOTAL shall ever appear on DrawX / DrawY.
REQ-029 Simultaneous hc and vc wrap in one cycle shall produce (0,0) with frame_start=1, vs=1, hs=1, blank=1 in that cycle.

Reset
REQ-030 While reset=1 at a rising edge: hc=0, vc=0, hs=1, vs=1, blank=0, frame_start=0, frame_count=0.
REQ-031 First edge with reset=0: DrawX=1, DrawY=0, blank=1, hs=1, vs=1; pixel (0,0) of the first frame after reset is intentionally reported blanked and frame_start is not pulsed until the next frame.
REQ-032 Reset asserted mid-frame takes effect at the next edge regardless of counter state; no partial-line completion.

Verification
REQ-033 Reset 3 cycles, release -> DrawX 0,0,0 then 1,2,3...; blank 0 during reset, 1 from first post-reset cycle; frame_count=0.
REQ-034 Run line 0 -> blank falls at DrawX=640; hs=0 for exactly 96 cycles, DrawX 656..751; DrawX 799 -> 0 with DrawY 0 -> 1.
REQ-035 Run full frame -> vs=0 for exactly 1600 cycles (DrawY 490..491); blank=0 for all DrawY >= 480.
REQ-036 Transition (799,524) -> (0,0) -> frame_start=1 for one cycle, frame_count +1; interval between frame_start pulses exactly 420000 cycles.
REQ-037 Run 256 frames -> frame_count wraps 255 -> 0.
REQ-038 Assert reset at (300,200) for 1 cycle -> next cycle DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_count=0; following cycle DrawX=1, blank=1.
